// File: rtl/fir_mac_group.sv
// fir_mac_group
// ---------------------------------------------------------------------------
// Sequential multiply-accumulate over one group of ten 3-bit signed taps.
// A start request snapshots the taps, then one tap x coefficient product is
// accumulated per clock; the result is published 11 clocks after the start.
//
// Ports
//   iClk12M     in   1          system clock (12 MHz), single domain
//   iRst        in   1          synchronous active-high reset
//   iEnMul      in   1          start pulse (ignored while busy)
//   iDelay      in   30         ten packed 3-bit signed taps, tap0 in [2:0]
//   iCoeffWr    in   1          coefficient write strobe (honoured in IDLE)
//   iCoeffAddr  in   4          coefficient index 0..9 (10..15 ignored)
//   iCoeffData  in   pCoeffW    signed coefficient value
//   oMac        out  pCoeffW+8  signed group sum, held between results
//   oValid      out  1          one-cycle pulse when oMac is updated
//   oBusy       out  1          high whenever the FSM is not IDLE
//
// Build option
//   FIR_MAC_SAT_EN  when defined, the published sum is clamped to the
//                   signed pCoeffW-bit range and sign-extended.
// ---------------------------------------------------------------------------
module fir_mac_group #(
    parameter int pCoeffW = 16
) (
    input  logic                 iClk12M,
    input  logic                 iRst,
    input  logic                 iEnMul,
    input  logic [29:0]          iDelay,
    input  logic                 iCoeffWr,
    input  logic [3:0]           iCoeffAddr,
    input  logic [pCoeffW-1:0]   iCoeffData,
    output logic [pCoeffW+7:0]   oMac,
    output logic                 oValid,
    output logic                 oBusy
);

    localparam int AccW  = pCoeffW + 8;
    localparam int ProdW = pCoeffW + 3;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                     state;
    state_t                     stateNext;
    logic signed [AccW-1:0]     acc;
    logic        [3:0]          cnt;
    logic signed [2:0]          tapSnap [10];
    logic signed [pCoeffW-1:0]  coeff   [10];

    logic signed [ProdW-1:0]    tapExt;
    logic signed [ProdW-1:0]    coeffExt;
    logic signed [ProdW-1:0]    prod;
    logic signed [AccW-1:0]     prodExt;

`ifdef FIR_MAC_SAT_EN
    // Clamp to the signed pCoeffW-bit range: in range exactly when the top
    // nine bits are all copies of the sign.
    function automatic logic signed [AccW-1:0] satFn(input logic signed [AccW-1:0] v);
        logic [8:0] top;
        top = v[AccW-1:pCoeffW-1];
        if (top == 9'h000 || top == 9'h1FF)
            return v;
        else if (v[AccW-1])
            return {{9{1'b1}}, {(pCoeffW-1){1'b0}}};
        else
            return {{9{1'b0}}, {(pCoeffW-1){1'b1}}};
    endfunction
`endif

    always_ff @(posedge iClk12M) begin
        if (iRst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iEnMul) stateNext = MAC;
            MAC:     if (cnt == 4'd9) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign oBusy = (state != IDLE);

    // Operands widened to the full product width before the multiply so the
    // signed product is exact.
    assign tapExt   = {{pCoeffW{tapSnap[cnt][2]}}, tapSnap[cnt]};
    assign coeffExt = {{3{coeff[cnt][pCoeffW-1]}}, coeff[cnt]};
    assign prod     = tapExt * coeffExt;
    assign prodExt  = {{(AccW-ProdW){prod[ProdW-1]}}, prod};

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            acc    <= '0;
            cnt    <= '0;
            oMac   <= '0;
            oValid <= 1'b0;
            for (int k = 0; k < 10; k++) begin
                tapSnap[k] <= '0;
                coeff[k]   <= '0;
            end
        end else begin
            oValid <= 1'b0;
            case (state)
                IDLE: begin
                    // A write coinciding with a start lands before the first
                    // accumulate cycle, so the run sees the new value.
                    if (iCoeffWr) begin
                        for (int k = 0; k < 10; k++)
                            if (iCoeffAddr == 4'(k)) coeff[k] <= iCoeffData;
                    end
                    if (iEnMul) begin
                        for (int k = 0; k < 10; k++)
                            tapSnap[k] <= iDelay[3*k +: 3];
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prodExt;
                    cnt <= cnt + 4'd1;
                end
                DONE: begin
`ifdef FIR_MAC_SAT_EN
                    oMac <= satFn(acc);
`else
                    oMac <= acc;
`endif
                    oValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_group.sv
module tb_fir_mac_group;

    logic               iClk12M = 1'b0;
    logic               iRst = 1'b1;
    logic               iEnMul = 1'b0;
    logic [29:0]        iDelay = '0;
    logic               iCoeffWr = 1'b0;
    logic [3:0]         iCoeffAddr = '0;
    logic [15:0]        iCoeffData = '0;
    logic signed [23:0] oMac;
    logic               oValid;
    logic               oBusy;

    int passCnt  = 0;
    int totalCnt = 0;

    fir_mac_group #(.pCoeffW(16)) dut (
        .iClk12M   (iClk12M),
        .iRst      (iRst),
        .iEnMul    (iEnMul),
        .iDelay    (iDelay),
        .iCoeffWr  (iCoeffWr),
        .iCoeffAddr(iCoeffAddr),
        .iCoeffData(iCoeffData),
        .oMac      (oMac),
        .oValid    (oValid),
        .oBusy     (oBusy)
    );

    always #5 iClk12M = ~iClk12M;

    task automatic tick();
        @(posedge iClk12M);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic writeCoeff(input int addr, input int data);
        iCoeffWr   = 1'b1;
        iCoeffAddr = 4'(addr);
        iCoeffData = 16'(data);
        tick();
        iCoeffWr = 1'b0;
    endtask

    // mode 0: plain run; 1: meddle with inputs at E3; 2: reset at E5;
    // 3: write coeff0=7 in the same cycle as the start.
    task automatic run(input logic [29:0] d, input int mode,
                       output int lat, output int pulses, output int busyCyc,
                       output longint val);
        iDelay = d;
        iEnMul = 1'b1;
        if (mode == 3) begin
            iCoeffWr = 1'b1; iCoeffAddr = 4'd0; iCoeffData = 16'd7;
        end
        tick();
        iEnMul = 1'b0; iCoeffWr = 1'b0;
        lat = -1; pulses = 0; busyCyc = int'(oBusy); val = 0;
        for (int n = 1; n <= 24; n++) begin
            if (mode == 1 && n == 3) begin
                iEnMul = 1'b1; iCoeffWr = 1'b1; iCoeffAddr = 4'd0;
                iCoeffData = 16'd5; iDelay = '0;
            end
            if (mode == 2 && n == 5) iRst = 1'b1;
            tick();
            iEnMul = 1'b0; iCoeffWr = 1'b0; iRst = 1'b0;
            busyCyc += int'(oBusy);
            if (oValid) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    val = longint'(oMac);
                end
            end
        end
    endtask

    initial begin
        int lat, pulses, busyCyc;
        longint val;
        logic [29:0] d;
        logic [2:0] t3;

        // reset
        tick(); tick();
        iRst = 1'b0;
        check("rst_mac", longint'(oMac), 0);
        check("rst_valid", longint'(oValid), 0);
        check("rst_busy", longint'(oBusy), 0);
        t3 = 3'b011;
        run({10{t3}}, 0, lat, pulses, busyCyc, val);
        check("rst_coeff_zero", val, 0);
        check("rst_run_pulses", pulses, 1);

        // basic sum
        for (int k = 0; k < 10; k++) writeCoeff(k, 1);
        run({10{t3}}, 0, lat, pulses, busyCyc, val);
        check("basic_latency", lat, 11);
        check("basic_sum", val, 30);
        check("basic_pulses", pulses, 1);
        check("basic_busy", busyCyc, 11);
        check("basic_hold", longint'(oMac), 30);

        // ordering and sign
        for (int k = 0; k < 10; k++) writeCoeff(k, k + 1);
        d = '0; d[29:27] = 3'b100;
        run(d, 0, lat, pulses, busyCyc, val);
        check("order_tap9", val, -40);
        d = '0; d[2:0] = 3'b001;
        run(d, 0, lat, pulses, busyCyc, val);
        check("order_tap0", val, 1);

        // write alongside start; out-of-range write ignored
        writeCoeff(10, 1000);
        writeCoeff(15, 1000);
        run(d, 3, lat, pulses, busyCyc, val);
        check("wr_with_start", val, 7);

        // busy rules: coeffs 7,2..10, taps all 3 -> 3*61
        run({10{t3}}, 1, lat, pulses, busyCyc, val);
        check("busy_pulses", pulses, 1);
        check("busy_latency", lat, 11);
        check("busy_snapshot", val, 183);
        run({10{t3}}, 0, lat, pulses, busyCyc, val);
        check("busy_coeff_kept", val, 183);

        // saturation
        for (int k = 0; k < 10; k++) writeCoeff(k, 32767);
        run({10{t3}}, 0, lat, pulses, busyCyc, val);
`ifdef FIR_MAC_SAT_EN
        check("sat_pos", val, 32767);
`else
        check("sat_pos", val, 983010);
`endif
        t3 = 3'b100;
        run({10{t3}}, 0, lat, pulses, busyCyc, val);
`ifdef FIR_MAC_SAT_EN
        check("sat_neg", val, -32768);
`else
        check("sat_neg", val, -1310680);
`endif
        check("sat_latency", lat, 11);

        // abort at E5
        t3 = 3'b011;
        run({10{t3}}, 2, lat, pulses, busyCyc, val);
        check("abort_pulses", pulses, 0);
        check("abort_busy", busyCyc, 5);
        check("abort_mac_cleared", longint'(oMac), 0);
        run({10{t3}}, 0, lat, pulses, busyCyc, val);
        check("abort_coeffs_zero", val, 0);
        check("abort_next_pulses", pulses, 1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/fir_mac_group.md
FIR_MAC_GROUP -- requirements
Module: fir_mac_group

Interface
REQ-001 Parameter: pCoeffW, default 16, signed coefficient width; oMac width SHALL be pCoeffW+8.
REQ-002 Port: iClk12M  input  1  system clock, 12 MHz; single clock domain.
REQ-003 Port: iRst  input  1  synchronous, active-high reset.
REQ-004 Port: iEnMul  input  1  start request, single-cycle pulse issued after each 600 kHz sample strobe.
REQ-005 Port: iDelay  input  30  ten packed 3-bit signed taps; tap k = iDelay[3k+2:3k], k=0..9, tap0 newest.
REQ-006 Port: iCoeffWr  input  1  coefficient write strobe.
REQ-007 Port: iCoeffAddr  input  4  coefficient index 0..9.
REQ-008 Port: iCoeffData  input  pCoeffW  signed coefficient value.
REQ-009 Port: oMac  output  pCoeffW+8  signed group sum of tap k x coeff k.
REQ-010 Port: oValid  output  1  one-cycle pulse; oMac updated.
REQ-011 Port: oBusy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, MAC, DONE.
REQ-013 In IDLE with iEnMul=1 at edge E0, the block SHALL snapshot iDelay, clear the accumulator, set tap counter to 0, and go to MAC.
REQ-014 At each edge E1..E10 in MAC, the accumulator SHALL add sign-extended tap[cnt] x coeff[cnt] and increment cnt; at E10 (cnt=9), the FSM SHALL go to DONE.
REQ-015 At E11 in DONE, the block SHALL load oMac from the accumulator, assert oValid for exactly one cycle, and return to IDLE.
REQ-016 Start-to-oValid latency SHALL be 11 clocks; the minimum start spacing SHALL be 12 clocks.
REQ-017 Multiplies and accumulation SHALL be signed, full precision; the accumulator SHALL be pCoeffW+8 bits and never overflow for 10 terms.
REQ-018 iDelay changes after E0 SHALL NOT affect the result, since only the snapshot is used.
REQ-019 iEnMul SHALL be ignored while oBusy=1, including in DONE; no queuing.
REQ-020 iCoeffWr with iCoeffAddr 0..9 SHALL write the coefficient register in IDLE only; writes while oBusy=1 or with address 10..15 SHALL be ignored.
REQ-021 If iCoeffWr and iEnMul are both high in IDLE, the write SHALL complete and the MAC SHALL use the new value.
REQ-022 oMac SHALL hold its value between oValid pulses.

Reset
REQ-023 iRst=1 SHALL force state to IDLE and clear accumulator, cnt, snapshot, all ten coefficients, oMac, oValid, and oBusy to 0 at the next edge.
REQ-024 A reset during MAC or DONE SHALL abort the operation with no oValid pulse; reset SHALL take priority over iEnMul and iCoeffWr.

Configuration
REQ-025 With macro FIR_MAC_SAT_EN defined, the value loaded into oMac SHALL be clamped to [-2^(pCoeffW-1), 2^(pCoeffW-1)-1], sign-extended to pCoeffW+8 bits.
REQ-026 Without FIR_MAC_SAT_EN, oMac SHALL be the unclamped full-precision accumulator; timing SHALL be identical in both builds.

Verification
REQ-027 Reset: assert iRst for 2 cycles -> oMac=0, oValid=0, oBusy=0; MAC with any taps returns 0.
REQ-028 Basic sum: coeffs all 1, iDelay all taps 3'b011, pulse iEnMul -> oValid exactly 11 clocks later, oMac=30, oBusy high for 11 cycles.
REQ-029 Ordering and sign: coeff k = k+1, only tap9=3'b100 (-4), other taps 0 -> oMac=-40; only tap0=1 -> oMac=1.
REQ-030 Saturation: coeffs all 32767, taps all 3'b011 -> oMac=983010 without FIR_MAC_SAT_EN, 32767 with it; taps all 3'b100 -> -1310680 without it, -32768 with it.
REQ-031 Busy rules: during MAC, pulse iEnMul, write coeff0=5, and change iDelay to all zeros -> a single oValid pulse, result unchanged from the E0 snapshot and old coefficients, and coeff0 still old on the next run.
REQ-032 Abort: assert iRst at E5 of a run -> oBusy=0 next cycle, no oValid pulse, coefficients read 0 on the next run.
